// File: rtl/riscv_test_monitor.sv
// riscv_test_monitor: end-of-test monitor for the RISC-V core.
// Snoops NUM_WPORTS register-file writeback ports and shadows the done, pass
// and test-number registers. After done==1 it waits SETTLE_CYCLES more cycles,
// then issues a sticky PASS/FAIL verdict, or TIMEOUT if the run takes too long.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start                     pulse, arms the monitor from IDLE
//   clr                       synchronous clear back to IDLE
//   wb_we/wb_waddr/wb_wdata   per-port writeback snoop, port i in slice i
//   finished/pass/fail/timeout verdict flags decoded from state
//   fail_testnum              test-number shadow, frozen at the verdict
//   cycle_count               saturating cycles spent in RUN+SETTLE
//   state                     IDLE=0 RUN=1 SETTLE=2 PASS=3 FAIL=4 TIMEOUT=5

// Per-port index decode; index 0 never matches because x0 is hardwired zero.
module riscv_test_monitor_wport #(
  parameter int ADDR_WIDTH = 5,
  parameter int DONE_REG   = 26,
  parameter int PASS_REG   = 27,
  parameter int TNUM_REG   = 3
) (
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  output logic                  done_hit_o,
  output logic                  pass_hit_o,
  output logic                  tnum_hit_o
);
  logic wr;
  assign wr         = we_i && (waddr_i != '0);
  assign done_hit_o = wr && (waddr_i == ADDR_WIDTH'(DONE_REG));
  assign pass_hit_o = wr && (waddr_i == ADDR_WIDTH'(PASS_REG));
  assign tnum_hit_o = wr && (waddr_i == ADDR_WIDTH'(TNUM_REG));
endmodule

module riscv_test_monitor #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int NUM_WPORTS     = 1,
  parameter int DONE_REG       = 26,
  parameter int PASS_REG       = 27,
  parameter int TNUM_REG       = 3,
  parameter int SETTLE_CYCLES  = 5,
  parameter int TIMEOUT_CYCLES = 25000,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           clr,
  input  logic [NUM_WPORTS-1:0]          wb_we,
  input  logic [NUM_WPORTS*ADDR_WIDTH-1:0] wb_waddr,
  input  logic [NUM_WPORTS*DATA_WIDTH-1:0] wb_wdata,
  output logic                           finished,
  output logic                           pass,
  output logic                           fail,
  output logic                           timeout,
  output logic [DATA_WIDTH-1:0]          fail_testnum,
  output logic [CNT_WIDTH-1:0]           cycle_count,
  output logic [2:0]                     state
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_RUN = 3'd1, S_SETTLE = 3'd2,
    S_PASS = 3'd3, S_FAIL = 3'd4, S_TIMEOUT = 3'd5
  } st_e;

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0]        S_LAST  = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  st_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0] done_q, done_d, pass_q, pass_d, tnum_q, tnum_d;
  logic [CNT_WIDTH-1:0] to_q, to_d, cc_q, cc_d;
  logic [SW-1:0]        st_q, st_d;
  logic [NUM_WPORTS-1:0] done_hit, pass_hit, tnum_hit;
  logic term, to_hit, settle_last;

  for (genvar g = 0; g < NUM_WPORTS; g++) begin : g_port
    riscv_test_monitor_wport #(
      .ADDR_WIDTH(ADDR_WIDTH), .DONE_REG(DONE_REG),
      .PASS_REG(PASS_REG), .TNUM_REG(TNUM_REG)
    ) u_wport (
      .we_i       (wb_we[g]),
      .waddr_i    (wb_waddr[g*ADDR_WIDTH +: ADDR_WIDTH]),
      .done_hit_o (done_hit[g]),
      .pass_hit_o (pass_hit[g]),
      .tnum_hit_o (tnum_hit[g])
    );
  end

  assign term        = (state_q == S_PASS) || (state_q == S_FAIL) || (state_q == S_TIMEOUT);
  assign to_hit      = (to_q == TO_LAST);
  // SETTLE_CYCLES of 0 or 1 both resolve on the first SETTLE cycle.
  assign settle_last = (SETTLE_CYCLES <= 1) || (st_q == S_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state; timeout outranks done and settle completion.
  always_comb begin
    state_d = state_q;
    if (clr) state_d = S_IDLE;
    else begin
      unique case (state_q)
        S_IDLE:   if (start) state_d = S_RUN;
        S_RUN:    if (to_hit) state_d = S_TIMEOUT;
                  else if (done_q == DATA_WIDTH'(1)) state_d = S_SETTLE;
        S_SETTLE: if (to_hit) state_d = S_TIMEOUT;
                  else if (settle_last)
                    state_d = (pass_q == DATA_WIDTH'(1)) ? S_PASS : S_FAIL;
        default:  state_d = state_q;
      endcase
    end
  end

  // Outputs decoded from the state register.
  always_comb begin
    finished     = term;
    pass         = (state_q == S_PASS);
    fail         = (state_q == S_FAIL);
    timeout      = (state_q == S_TIMEOUT);
    fail_testnum = term ? tnum_q : '0;
    cycle_count  = cc_q;
    state        = state_q;
  end

  // Shadows: ascending port loop so the highest port wins on a collision.
  always_comb begin
    done_d = done_q;
    pass_d = pass_q;
    tnum_d = tnum_q;
    if (clr) begin
      done_d = '0;
      pass_d = '0;
      tnum_d = '0;
    end else if (!term) begin
      for (int i = 0; i < NUM_WPORTS; i++) begin
        if (done_hit[i]) done_d = wb_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        if (pass_hit[i]) pass_d = wb_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        if (tnum_hit[i]) tnum_d = wb_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Counters
  always_comb begin
    to_d = to_q;
    cc_d = cc_q;
    st_d = '0;
    if (clr) begin
      to_d = '0;
      cc_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (start) begin
          to_d = '0;
          cc_d = '0;
        end
        S_RUN, S_SETTLE: begin
          to_d = to_q + 1'b1;
          if (cc_q != '1) cc_d = cc_q + 1'b1;
          if (state_q == S_SETTLE) st_d = st_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= '0;
      pass_q <= '0;
      tnum_q <= '0;
      to_q   <= '0;
      cc_q   <= '0;
      st_q   <= '0;
    end else begin
      done_q <= done_d;
      pass_q <= pass_d;
      tnum_q <= tnum_d;
      to_q   <= to_d;
      cc_q   <= cc_d;
      st_q   <= st_d;
    end
  end
endmodule

// File: tb/tb_riscv_test_monitor.sv
// Directed bench for riscv_test_monitor: two writeback ports, timeout of 100,
// settle window of 5. Cycle c means the c-th rising edge after the start edge.
module tb_riscv_test_monitor;
  logic        clk = 1'b0;
  logic        rst, start, clr;
  logic [1:0]  wb_we;
  logic [9:0]  wb_waddr;
  logic [63:0] wb_wdata;
  logic        finished, pass, fail, timeout;
  logic [31:0] fail_testnum, cycle_count;
  logic [2:0]  state;

  int total = 0;
  int bad   = 0;

  riscv_test_monitor #(.NUM_WPORTS(2), .TIMEOUT_CYCLES(100), .SETTLE_CYCLES(5)) dut (
    .clk(clk), .rst(rst), .start(start), .clr(clr),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .finished(finished), .pass(pass), .fail(fail), .timeout(timeout),
    .fail_testnum(fail_testnum), .cycle_count(cycle_count), .state(state)
  );

  always #5 clk = ~clk;

  // Writes: tn/p/z on port 0, d/pa on port 1; cycle 0 means "no write".
  typedef struct {
    int tn_cyc; int tn_val;
    int p_cyc;  int p_val;
    int pa_cyc; int pa_val;
    int z_cyc;
    int d_cyc;  int d_val;
    int e_state; int e_cyc; int e_cc; int e_ftn;
  } vec_t;

  vec_t vt[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic idle_bus();
    wb_we = '0; wb_waddr = '0; wb_wdata = '0;
  endtask

  task automatic drive(input vec_t v, input int c);
    logic [1:0]  we;
    logic [9:0]  ad;
    logic [63:0] da;
    we = '0; ad = '0; da = '0;
    if (v.tn_cyc == c) begin we[0] = 1'b1; ad[4:0] = 5'd3;  da[31:0] = v.tn_val; end
    if (v.p_cyc  == c) begin we[0] = 1'b1; ad[4:0] = 5'd27; da[31:0] = v.p_val;  end
    if (v.z_cyc  == c) begin we[0] = 1'b1; ad[4:0] = 5'd0;  da[31:0] = 32'd1;    end
    if (v.d_cyc  == c) begin we[1] = 1'b1; ad[9:5] = 5'd26; da[63:32] = v.d_val; end
    if (v.pa_cyc == c) begin we[1] = 1'b1; ad[9:5] = 5'd27; da[63:32] = v.pa_val; end
    wb_we = we; wb_waddr = ad; wb_wdata = da;
  endtask

  task automatic clear_and_start();
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_idle_state", {29'd0, state}, 32'd0);
    chk("clr_idle_count", cycle_count, 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    chk("start_run", {29'd0, state}, 32'd1);
  endtask

  task automatic run_vec(input int k, input vec_t v);
    int fcyc;
    bit fin;
    string s;
    fin = 0; fcyc = 0;
    clear_and_start();
    for (int c = 1; c <= 150 && !fin; c++) begin
      drive(v, c);
      tick();
      idle_bus();
      if (finished) begin fin = 1; fcyc = c; end
    end
    s = $sformatf("v%0d", k);
    if (!fin) chk({s, "_no_verdict"}, 32'd0, 32'd1);
    chk({s, "_cycle"},   fcyc, v.e_cyc);
    chk({s, "_state"},   {29'd0, state}, v.e_state);
    chk({s, "_pass"},    {31'd0, pass},    {31'd0, v.e_state == 3});
    chk({s, "_fail"},    {31'd0, fail},    {31'd0, v.e_state == 4});
    chk({s, "_timeout"}, {31'd0, timeout}, {31'd0, v.e_state == 5});
    chk({s, "_count"},   cycle_count, v.e_cc);
    chk({s, "_testnum"}, fail_testnum, v.e_ftn);
    // Terminal state is sticky and freezes the count and shadows.
    start = 1'b1;
    drive('{1, 99, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 1);
    repeat (3) tick();
    start = 1'b0; idle_bus();
    chk({s, "_sticky_state"}, {29'd0, state}, v.e_state);
    chk({s, "_sticky_count"}, cycle_count, v.e_cc);
    chk({s, "_sticky_testnum"}, fail_testnum, v.e_ftn);
  endtask

  initial begin
    //        tn_c tn_v p_c p_v pa_c pa_v z  d_c d_v  st cyc cc  ftn
    vt[0]  = '{5,  1,   10, 1,  0,   0,   0, 20, 1,   3, 26, 26, 1};  // basic pass
    vt[1]  = '{2,  7,   3,  0,  0,   0,   0, 4,  1,   4, 10, 10, 7};  // fail
    vt[2]  = '{1,  3,   23, 1,  0,   0,   0, 20, 1,   3, 26, 26, 3};  // late pass inside window
    vt[3]  = '{1,  4,   26, 1,  0,   0,   0, 20, 1,   4, 26, 26, 4};  // pass on verdict edge: too late
    vt[4]  = '{1,  9,   0,  0,  0,   0,   0, 0,  0,   5, 100, 100, 9}; // timeout
    vt[5]  = '{1,  2,   0,  0,  0,   0,   0, 5,  2,   5, 100, 100, 2}; // done!=1 ignored
    vt[6]  = '{1,  5,   3,  1,  0,   0,   0, 93, 1,   3, 99, 99, 5};  // verdict one before timeout
    vt[7]  = '{1,  6,   3,  1,  0,   0,   0, 94, 1,   5, 100, 100, 6}; // verdict ties timeout
    vt[8]  = '{1,  8,   3,  1,  0,   0,   0, 97, 1,   5, 100, 100, 8}; // timeout inside SETTLE
    vt[9]  = '{0,  0,   1,  0,  1,   1,   0, 2,  1,   3, 8,  8,  0};  // port1 wins: pass
    vt[10] = '{0,  0,   1,  1,  1,   0,   0, 2,  1,   4, 8,  8,  0};  // port1 wins: fail
    vt[11] = '{0,  0,   0,  0,  0,   0,   2, 0,  0,   5, 100, 100, 0}; // x0 write ignored

    rst = 1'b1; start = 1'b0; clr = 1'b0; idle_bus();
    repeat (2) tick();
    chk("rst_state",    {29'd0, state}, 32'd0);
    chk("rst_finished", {31'd0, finished}, 32'd0);
    chk("rst_count",    cycle_count, 32'd0);
    chk("rst_testnum",  fail_testnum, 32'd0);
    rst = 1'b0;
    tick();

    for (int k = 0; k < 12; k++) run_vec(k, vt[k]);

    // start during RUN is ignored; done after TIMEOUT does not move it.
    begin
      bit fin;
      fin = 0;
      clear_and_start();
      repeat (5) tick();
      start = 1'b1; tick(); start = 1'b0;
      chk("rerun_state", {29'd0, state}, 32'd1);
      chk("rerun_count", cycle_count, 32'd6);
      for (int c = 7; c <= 200 && !fin; c++) begin
        tick();
        if (finished) fin = 1;
      end
      chk("late_to_state", {29'd0, state}, 32'd5);
      chk("late_to_count", cycle_count, 32'd100);
      wb_we = 2'b10; wb_waddr = {5'd26, 5'd0}; wb_wdata = {32'd1, 32'd0};
      repeat (3) tick();
      idle_bus();
      chk("to_done_ignored", {29'd0, state}, 32'd5);
    end

    // Async reset mid-SETTLE, then shadows must have been wiped.
    clear_and_start();
    wb_we = 2'b10; wb_waddr = {5'd26, 5'd0}; wb_wdata = {32'd1, 32'd0};
    tick(); idle_bus();
    tick(); tick();
    chk("pre_rst_settle", {29'd0, state}, 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("arst_state", {29'd0, state}, 32'd0);
    chk("arst_count", cycle_count, 32'd0);
    chk("arst_finished", {31'd0, finished}, 32'd0);
    @(negedge clk); rst = 1'b0;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    repeat (20) tick();
    chk("post_rst_run", {29'd0, state}, 32'd1);
    chk("post_rst_count", cycle_count, 32'd20);

    // clr out of PASS, next start behaves normally.
    run_vec(12, vt[0]);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_pass_state", {29'd0, state}, 32'd0);
    chk("clr_pass_flag", {31'd0, pass}, 32'd0);
    run_vec(13, vt[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
